// File: rtl/regfile_dump_ctrl.sv
// Sweeps CPU registers R0..R15 over the four-phase debug read port into a shadow buffer.
// Each handshake phase is bounded by TIMEOUT_CYCLES; timeouts force progress and set a sticky error.
module regfile_dump_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit AUTO_RESTART   = 1'b0
) (
    input  logic        PCLK,
    input  logic        RST,
    input  logic        start,
    output logic        regfile_request,
    output logic [3:0]  regfile_ra,
    input  logic        regfile_grant,
    input  logic [15:0] regfile_rd,
    input  logic [3:0]  sel,
    output logic [15:0] sel_data,
    output logic [15:0] valid_mask,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    ra_q, ra_d;
    logic          req_q, req_d;
    logic [15:0]   mask_q, mask_d;
    logic          done_q, done_d;
    logic          terr_q, terr_d;
    logic          grant_q;
    logic          shadow_we;
    logic [15:0]   shadow_q [16];

    logic grant_rise;
    logic cnt_last;

    // Only a fresh low-to-high grant counts; a grant already high is stale.
    assign grant_rise = regfile_grant & ~grant_q;
    assign cnt_last   = (cnt_q == CNT_LAST);

    always_ff @(posedge PCLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ra_q    <= '0;
            req_q   <= 1'b0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            grant_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ra_q    <= ra_d;
            req_q   <= req_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            grant_q <= regfile_grant;
            if (shadow_we) begin
                shadow_q[ra_q] <= regfile_rd;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ra_d      = ra_q;
        req_d     = req_q;
        mask_d    = mask_q;
        done_d    = 1'b0;
        terr_d    = terr_q;
        shadow_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    ra_d    = '0;
                    mask_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (grant_rise) begin
                    shadow_we    = 1'b1;
                    mask_d[ra_q] = 1'b1;
                    req_d        = 1'b0;
                    state_d      = S_REL;
                    cnt_d        = '0;
                end else if (cnt_last) begin
                    terr_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_REL;
                    cnt_d   = '0;
                end
            end
            S_REL: begin
                cnt_d = cnt_q + 1'b1;
                if (!regfile_grant || cnt_last) begin
                    if (regfile_grant) begin
                        terr_d = 1'b1;
                    end
                    cnt_d = '0;
                    if (ra_q == 4'd15) begin
                        done_d = 1'b1;
                        if (AUTO_RESTART) begin
                            ra_d    = '0;
                            req_d   = 1'b1;
                            mask_d  = '0;
                            state_d = S_REQ;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        ra_d    = ra_q + 4'd1;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        regfile_request = req_q;
        regfile_ra      = ra_q;
        busy            = (state_q != S_IDLE);
        done            = done_q;
        timeout_err     = terr_q;
        valid_mask      = mask_q;
        sel_data        = shadow_q[sel];
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: a register-level scoreboard (shadow, mask, sticky error)
// is compared every cycle, plus literal spot checks; a second instance covers continuous refresh.
module tb_regfile_dump_ctrl;

    logic PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic        RST, start, grant;
    logic [15:0] rd;
    logic        regfile_request, busy, done, timeout_err;
    logic [3:0]  regfile_ra, sel, sel_cnt, sel_pin;
    logic [15:0] sel_data, valid_mask;
    logic        sel_hold;

    logic        rst_ar, start_ar, req_ar, busy_ar, done_ar, terr_ar;
    logic [3:0]  ra_ar;
    logic [3:0]  sel_ar;
    logic [15:0] sel_data_ar, mask_ar;

    assign sel = sel_hold ? sel_pin : sel_cnt;

    regfile_dump_ctrl #(.TIMEOUT_CYCLES(64), .AUTO_RESTART(1'b0)) dut (
        .PCLK(PCLK), .RST(RST), .start(start),
        .regfile_request(regfile_request), .regfile_ra(regfile_ra),
        .regfile_grant(grant), .regfile_rd(rd),
        .sel(sel), .sel_data(sel_data), .valid_mask(valid_mask),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    regfile_dump_ctrl #(.TIMEOUT_CYCLES(64), .AUTO_RESTART(1'b1)) dut_ar (
        .PCLK(PCLK), .RST(rst_ar), .start(start_ar),
        .regfile_request(req_ar), .regfile_ra(ra_ar),
        .regfile_grant(grant), .regfile_rd(rd),
        .sel(sel_ar), .sel_data(sel_data_ar), .valid_mask(mask_ar),
        .busy(busy_ar), .done(done_ar), .timeout_err(terr_ar)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int n_done_ar = 0;

    // Scoreboard: last value served per register, registers served this sweep, sticky error.
    logic [15:0] exp_shadow [16];
    logic [15:0] exp_mask;
    logic        exp_terr;
    bit          chk_en = 1'b0;
    bit          chk_nr = 1'b0;
    logic        req_prev = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge PCLK) begin
        if (chk_en) begin
            chk("sel_data", 32'(sel_data), 32'(exp_shadow[sel]));
            chk("valid_mask", 32'(valid_mask), 32'(exp_mask));
            chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
            if (chk_nr && regfile_request && !req_prev)
                chk("req_rise_while_grant", 32'(grant), 32'd0);
        end
        if (done === 1'b1) n_done++;
        if (done_ar === 1'b1) n_done_ar++;
        req_prev <= regfile_request;
    end

    initial begin
        sel_cnt = '0;
        forever begin
            @(posedge PCLK); #1;
            sel_cnt = sel_cnt + 4'd1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    function automatic logic g_req(bit w);
        return w ? req_ar : regfile_request;
    endfunction
    function automatic logic [3:0] g_ra(bit w);
        return w ? ra_ar : regfile_ra;
    endfunction
    function automatic logic g_done(bit w);
        return w ? done_ar : done;
    endfunction
    function automatic logic g_busy(bit w);
        return w ? busy_ar : busy;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_shadow[i] = '0;
        exp_mask = '0;
        exp_terr = 1'b0;
    endtask

    task automatic pulse_start(bit w);
        if (w) start_ar = 1'b1; else start = 1'b1;
        @(posedge PCLK);
        if (!w) exp_mask = '0;
        #1;
        start = 1'b0;
        start_ar = 1'b0;
    endtask

    task automatic wait_req(bit w, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge PCLK); #1;
            if (g_req(w)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_req: request stayed 0, required 1 within 200 cycles");
        end
    endtask

    // Responder: grant one cycle after request (plus dly), release one cycle after request drops.
    task automatic serve(bit w, int i, int dly, logic [15:0] d);
        bit ok;
        wait_req(w, ok);
        if (!ok) return;
        chk("ra_on_req", 32'(g_ra(w)), 32'(i));
        repeat (1 + dly) begin
            @(posedge PCLK); #1;
            chk("req_held", 32'(g_req(w)), 32'd1);
            chk("ra_held", 32'(g_ra(w)), 32'(i));
            rd = 16'hFFFF;
        end
        grant = 1'b1;
        rd = d;
        @(posedge PCLK);
        if (!w) begin
            exp_shadow[i] = d;
            exp_mask[i] = 1'b1;
        end
        #1;
        rd = ~d;
        chk("req_drop", 32'(g_req(w)), 32'd0);
        @(posedge PCLK); #1;
        grant = 1'b0;
        if (i == 15) begin
            @(posedge PCLK); #1;
            chk("done", 32'(g_done(w)), 32'd1);
            chk("busy_at_done", 32'(g_busy(w)), 32'(w));
            if (w) begin
                chk("ar_req_restart", 32'(req_ar), 32'd1);
                chk("ar_ra_restart", 32'(ra_ar), 32'd0);
                chk("ar_mask_cleared", 32'(mask_ar), 32'd0);
            end
            @(posedge PCLK); #1;
            chk("done_width", 32'(g_done(w)), 32'd0);
        end
    endtask

    task automatic serve_timeout(bit w, int i);
        bit ok;
        wait_req(w, ok);
        if (!ok) return;
        chk("ra_on_req_to", 32'(g_ra(w)), 32'(i));
        repeat (63) begin
            @(posedge PCLK); #1;
            chk("req_wait_to", 32'(g_req(w)), 32'd1);
        end
        @(posedge PCLK);
        if (!w) exp_terr = 1'b1;
        #1;
        chk("req_drop_to", 32'(g_req(w)), 32'd0);
    endtask

    task automatic spot(logic [3:0] s, logic [15:0] expv, string name);
        sel_hold = 1'b1;
        sel_pin = s;
        #1;
        chk(name, 32'(sel_data), 32'(expv));
        sel_hold = 1'b0;
    endtask

    initial begin
        int snap;
        RST = 1'b1; start = 1'b0; grant = 1'b0; rd = '0;
        rst_ar = 1'b1; start_ar = 1'b0; sel_ar = 4'd7;
        sel_hold = 1'b0; sel_pin = '0;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        chk_en = 1'b1;
        chk("rst_request", 32'(regfile_request), 32'd0);
        chk("rst_ra", 32'(regfile_ra), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mask", 32'(valid_mask), 32'd0);
        RST = 1'b0;

        // Clean sweep
        chk_nr = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 16; i++) serve(1'b0, i, 0, 16'h1000 + 16'(i));
        chk("sweep1_done_count", 32'(n_done), 32'd1);
        chk("sweep1_mask", 32'(valid_mask), 32'h0000_FFFF);
        chk("sweep1_terr", 32'(timeout_err), 32'd0);
        spot(4'd7, 16'h1007, "sweep1_sel7");

        // R3 delayed by 10 cycles, R5 never granted
        pulse_start(1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) serve(1'b0, 3, 10, 16'h2003);
            else if (i == 5) serve_timeout(1'b0, 5);
            else serve(1'b0, i, 0, 16'h2000 + 16'(i));
        end
        chk("sweep2_done_count", 32'(n_done), 32'd2);
        chk("sweep2_mask", 32'(valid_mask), 32'h0000_FFDF);
        chk("sweep2_terr", 32'(timeout_err), 32'd1);
        spot(4'd5, 16'h1005, "sweep2_sel5_kept");
        spot(4'd3, 16'h2003, "sweep2_sel3_rise_value");

        // Reset while R9 is requested
        pulse_start(1'b0);
        for (int i = 0; i < 9; i++) serve(1'b0, i, 0, 16'h4000 + 16'(i));
        begin
            bit ok;
            wait_req(1'b0, ok);
            chk("ra_before_rst", 32'(regfile_ra), 32'd9);
        end
        snap = n_done;
        chk_nr = 1'b0;
        RST = 1'b1;
        grant = 1'b1;
        @(posedge PCLK);
        model_reset();
        #1;
        RST = 1'b0;
        chk("midrst_request", 32'(regfile_request), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mask", 32'(valid_mask), 32'd0);
        repeat (20) begin
            @(posedge PCLK); #1;
            chk("idle_no_req", 32'(regfile_request), 32'd0);
        end
        chk("midrst_no_done", 32'(n_done), 32'(snap));

        // Grant stuck high: R0 times out in REQ and REL, then grant released
        pulse_start(1'b0);
        chk("stuck_req", 32'(regfile_request), 32'd1);
        chk("stuck_ra0", 32'(regfile_ra), 32'd0);
        repeat (63) begin
            @(posedge PCLK); #1;
            chk("stuck_req_wait", 32'(regfile_request), 32'd1);
        end
        @(posedge PCLK);
        exp_terr = 1'b1;
        #1;
        chk("stuck_req_drop", 32'(regfile_request), 32'd0);
        repeat (63) begin
            @(posedge PCLK); #1;
            chk("stuck_rel_wait", 32'(regfile_request), 32'd0);
        end
        @(posedge PCLK); #1;
        chk("stuck_rel_exit_req", 32'(regfile_request), 32'd1);
        chk("stuck_rel_exit_ra", 32'(regfile_ra), 32'd1);
        grant = 1'b0;
        serve(1'b0, 1, 0, 16'h3001);
        chk_nr = 1'b1;
        for (int i = 2; i < 16; i++) serve(1'b0, i, 0, 16'h3000 + 16'(i));
        chk("sweep4_done_count", 32'(n_done), 32'(snap + 1));
        chk("sweep4_mask", 32'(valid_mask), 32'h0000_FFFE);
        chk("sweep4_terr", 32'(timeout_err), 32'd1);
        spot(4'd0, 16'h0000, "sweep4_sel0");
        spot(4'd1, 16'h3001, "sweep4_sel1");
        chk_nr = 1'b0;

        // Continuous refresh instance
        rst_ar = 1'b0;
        @(posedge PCLK); #1;
        chk("ar_idle_busy", 32'(busy_ar), 32'd0);
        pulse_start(1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) pulse_start(1'b1);
            serve(1'b1, i, 0, 16'h5000 + 16'(i));
        end
        for (int i = 0; i < 16; i++) serve(1'b1, i, 0, 16'h6000 + 16'(i));
        chk("ar_done_count", 32'(n_done_ar), 32'd2);
        chk("ar_sel7", 32'(sel_data_ar), 32'h0000_6007);
        chk("ar_terr", 32'(terr_ar), 32'd0);
        rst_ar = 1'b1;
        @(posedge PCLK); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Initiator side of the CPU's register-file debug read port (regfile_request/ra out, regfile_grant/rd in).
- Sweeps architectural registers R0..R15, one four-phase handshake per register, into a 16x16 shadow buffer.
- The display/UART front-end reads the shadow buffer asynchronously via a select port.
- Runs in the PCLK domain, so it is cycle-aligned with the pipeline.

Parameters:
- TIMEOUT_CYCLES, 64: max PCLK cycles spent in REQ or REL before forcing progress; must be ≥2.
- AUTO_RESTART, 0: 1 = after R15 completes, immediately restart at R0 (continuous refresh).

Ports:
- PCLK  input  1  pipeline clock
- RST  input  1  reset
- start  input  1  one-cycle pulse; begins a sweep when idle
- regfile_request  output  1  request to CPU; registered
- regfile_ra  output  4  register address; registered, stable while request high
- regfile_grant  input  1  CPU grant; rising edge marks rd valid
- regfile_rd  input  16  CPU read data
- sel  input  4  shadow buffer read address
- sel_data  output  16  shadow[sel], combinational
- valid_mask  output  16  bit i set once R[i] captured in the current sweep
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a sweep finishes
- timeout_err  output  1  sticky; set on any grant timeout

Behaviour:
- Reset RST is synchronous, active-high; clock PCLK.
- Reset values: regfile_request=0, regfile_ra=0, busy=0, done=0, timeout_err=0, valid_mask=0, all shadow entries=0, grant_q=0, timeout counter=0, state=IDLE.
- grant_q is a registered copy of regfile_grant; rise = regfile_grant & ~grant_q.
- States: IDLE, REQ, REL.
- IDLE:
  - start=1 -> REQ; request=1 and ra=0 from the next edge.
  - Entering a sweep clears valid_mask to 0 in the same edge.
  - timeout_err is not cleared by a new sweep.
- REQ:
  - On rise: shadow[ra]<=rd; valid_mask[ra]<=1; request<=0; -> REL.
  - rd is sampled in the same cycle the rise is seen.
  - Counter reaches TIMEOUT_CYCLES-1 with no rise: timeout_err<=1; request<=0; shadow unchanged; mask bit stays 0; -> REL.
- REL:
  - Waits for regfile_grant==0, sampled directly.
  - Then, if ra==15: done pulse for 1 cycle.
    - AUTO_RESTART=0: -> IDLE.
    - AUTO_RESTART=1: ra<=0, request<=1, mask cleared, -> REQ.
  - Otherwise: ra<=ra+1, request<=1, -> REQ.
  - REL timeout (grant still high at TIMEOUT_CYCLES-1): timeout_err<=1; proceed as if released.
- Timeout counter: clears on every state entry and counts each cycle spent in REQ/REL.
- Grant already high on entering REQ: no rise, so the block times out. Stale grants are never captured.
- start while busy: ignored.
- ra wrap: ra never exceeds 15; the sweep ends on 15 rather than wrapping, except under AUTO_RESTART.
- Minimum per-register cost, grant responding in 1 cycle each phase: 4 PCLK cycles. Full sweep ≥64 cycles.
- RST mid-sweep: request drops at that edge, the sweep is aborted, and no done pulse is issued.
- The block does not gate on PAUSE. The CPU is responsible for granting while stepped.

Test Plan:
- Reset, then start; responder grants 1 cycle after request, value 16'h1000+i for R[i]. Required:
  - done after the R15 handshake; valid_mask=16'hFFFF.
  - sel=4'd7 -> sel_data=16'h1007.
  - timeout_err=0.
  - request never rises while grant is high.
- Responder delays grant for R3 by 10 cycles (TIMEOUT_CYCLES=64): ra held at 3 and request held high throughout the wait; shadow[3] gets the value present on the rise cycle, not later changes.
- Responder never grants R5: after 64 cycles in REQ, timeout_err=1 and request drops. Final valid_mask=16'hFFDF; shadow[5] keeps its prior value; done still pulses.
- Grant held high from reset, then start: R0 times out; REL times out; timeout_err=1. Release grant mid-sweep: subsequent registers captured normally.
- Assert RST when ra=9 in REQ: request=0, busy=0, valid_mask=0, done never pulses. A new start sweeps from R0.
- AUTO_RESTART=1: after R15, done pulses and request re-asserts with ra=0. A second start pulse during the sweep has no effect. Two consecutive sweeps produce two done pulses.
